// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART transmitter and receiver: the frame FSM
//   state encoding, the frame data width, the line idle level and the default
//   bit period.
//
//   Optional feature macro: UART_TRANSMITTER_PARITY_EN
//     When defined, the PARITY state exists and an even parity bit is sent
//     between data bit 7 and the stop bit.
//
//   Contents:
//     FRAME_DATA_BITS      data bits per frame (8)
//     IDLE_LEVEL           serial line level when nothing is sent (1)
//     DEFAULT_CLKS_PER_BIT default clk cycles per serial bit period (16)
//     uart_state_e         frame FSM states
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int   FRAME_DATA_BITS      = 8;
    localparam logic IDLE_LEVEL           = 1'b1;
    localparam int   DEFAULT_CLKS_PER_BIT = 16;

`ifdef UART_TRANSMITTER_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd4
    } uart_state_e;
`endif

endpackage : uart_pkg

// File: rtl/uart_transmitter_if.sv
// ----------------------------------------------------------------------------
// uart_transmitter_if
//   Byte-offer handshake between a producer and the UART transmitter.
//   A byte moves on a rising clk edge where valid=1 and ready=1.
//
//   Signals:
//     data  [7:0]  byte offered by the producer
//     valid        producer offers data this cycle
//     ready        transmitter can take a byte this cycle (registered)
//
//   Modports:
//     master  producer side   (drives data/valid, sees ready)
//     slave   transmitter side (sees data/valid, drives ready)
// ----------------------------------------------------------------------------
interface uart_transmitter_if;
    import uart_pkg::*;

    logic [FRAME_DATA_BITS-1:0] data;
    logic                       valid;
    logic                       ready;

    modport master (
        output data,
        output valid,
        input  ready
    );

    modport slave (
        input  data,
        input  valid,
        output ready
    );

endinterface : uart_transmitter_if

// File: rtl/uart_baud_gen.sv
// ----------------------------------------------------------------------------
// uart_baud_gen
//   Bit-period timer. Counts clk cycles from 0 to CLKS_PER_BIT-1 and wraps.
//   tick is high during the last cycle of each bit period, so a consumer that
//   advances on tick holds every bit for exactly CLKS_PER_BIT cycles.
//
//   Parameters:
//     CLKS_PER_BIT  clk cycles per serial bit, legal range 2..65535
//
//   Ports:
//     clk      clock, rising edge
//     rst_n    synchronous active-low reset, clears the counter
//     restart  forces the counter to 0 on the next edge (state entry / idle)
//     tick     last cycle of the current bit period
// ----------------------------------------------------------------------------
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    // Fixed 16-bit width covers the whole legal range, including 2 where
    // $clog2 would collapse to a single bit.
    localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_BIT - 1);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // tick comes straight from the register so it can feed the FSM's
    // next-state logic, which in turn drives restart, without a loop.
    assign tick = (count_q == LAST_COUNT);

    // NOTE: every signal written in an always_comb gets a default first;
    // a path that leaves it unassigned would infer a latch.
    always_comb begin
        count_d = count_q + 16'd1;
        if (restart || tick) begin
            count_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : uart_baud_gen

// File: rtl/uart_transmitter.sv
// ----------------------------------------------------------------------------
// uart_transmitter
//   8N1 UART transmitter (8E1 with the optional parity feature). A byte is
//   accepted through a valid/ready handshake, latched into a shift register
//   and sent LSB first: start bit (0), 8 data bits, [even parity], stop (1).
//
//   Optional feature macro: UART_TRANSMITTER_PARITY_EN
//     Defined   -> PARITY state inserted, frame is 11 bit periods.
//     Undefined -> no parity state or logic, frame is 10 bit periods.
//
//   Parameters:
//     CLKS_PER_BIT  clk cycles per serial bit, legal range 2..65535
//
//   Ports:
//     clk     clock, all logic on the rising edge
//     rst_n   synchronous active-low reset; abandons any frame in flight
//     tx      byte handshake (slave modport): data, valid in; ready out
//     serial  registered serial line, idles at 1
//     busy    registered, high exactly while a frame is on the line
//
//   Timing: serial, busy and ready are all registered. serial/busy follow the
//   FSM state one cycle late, so the start bit appears on the edge after the
//   accepting edge and the line frame lasts exactly N*CLKS_PER_BIT cycles.
//   ready is registered from the next state, so it rises together with the
//   return to IDLE and a byte held on valid is taken on the following edge.
// ----------------------------------------------------------------------------
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_transmitter_if.slave tx,
    output logic              serial,
    output logic              busy
);

    localparam logic [2:0] LAST_BIT_IDX = 3'(FRAME_DATA_BITS - 1);

    uart_state_e                state_q;
    uart_state_e                state_d;
    logic [FRAME_DATA_BITS-1:0] shift_q;
    logic [FRAME_DATA_BITS-1:0] shift_d;
    logic [2:0]                 bit_idx_q;
    logic [2:0]                 bit_idx_d;
    logic                       serial_q;
    logic                       serial_d;
    logic                       ready_q;
    logic                       ready_d;
    logic                       busy_q;
    logic                       busy_d;
`ifdef UART_TRANSMITTER_PARITY_EN
    logic                       parity_q;
    logic                       parity_d;
`endif

    logic tick;
    logic restart;
    logic accept;

    // ------------------------------------------------------------------
    // Bit-period timer. It is held at 0 while idle and cleared on every
    // state change, so each state starts with a full bit period.
    // ------------------------------------------------------------------
    assign restart = (state_q == IDLE) || (state_d != state_q);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .tick    (tick)
    );

    // ready_q is only ever 1 in IDLE; checking the state as well keeps the
    // handshake safe against any future change to how ready is produced.
    assign accept = tx.valid && ready_q && (state_q == IDLE);

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        serial_d  = IDLE_LEVEL;
`ifdef UART_TRANSMITTER_PARITY_EN
        parity_d  = parity_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    shift_d = tx.data;
`ifdef UART_TRANSMITTER_PARITY_EN
                    parity_d = ^tx.data;
`endif
                end
            end

            START: begin
                serial_d = 1'b0;
                if (tick) begin
                    state_d = DATA;
                end
            end

            DATA: begin
                serial_d = shift_q[0];
                if (tick) begin
                    shift_d   = {1'b0, shift_q[FRAME_DATA_BITS-1:1]};
                    // 3-bit index wraps 7 -> 0 exactly on leaving DATA.
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == LAST_BIT_IDX) begin
`ifdef UART_TRANSMITTER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end

`ifdef UART_TRANSMITTER_PARITY_EN
            PARITY: begin
                serial_d = parity_q;
                if (tick) begin
                    state_d = STOP;
                end
            end
`endif

            STOP: begin
                serial_d = IDLE_LEVEL;
                if (tick) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Line-facing flags follow the current state and are registered
        // below, keeping them aligned with serial.
        busy_d  = (state_q != IDLE);
        // ready follows the next state so it rises on the same edge that
        // returns the FSM to IDLE.
        ready_d = (state_d == IDLE);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            // NOTE: the shift register is reset along with the control
            // state; it is small, and a defined value keeps the datapath
            // free of X after reset even though it is always reloaded on
            // accept before use.
            shift_q   <= '0;
            bit_idx_q <= '0;
            serial_q  <= IDLE_LEVEL;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_TRANSMITTER_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            serial_q  <= serial_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
`ifdef UART_TRANSMITTER_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign tx.ready = ready_q;
    assign serial   = serial_q;
    assign busy     = busy_q;

endmodule : uart_transmitter

// File: tb/tb_uart_transmitter.sv
// ----------------------------------------------------------------------------
// tb_uart_transmitter
//   Self-checking bench for uart_transmitter at CLKS_PER_BIT=16.
//   A table of bytes with hand-written bit orders and parity is sent one
//   frame at a time; every cycle of every bit is compared against the
//   expected level. Hand-written sequences cover back-to-back frames,
//   input changes mid-frame, reset mid-frame and a loopback receiver.
//   Builds with or without UART_TRANSMITTER_PARITY_EN.
// ----------------------------------------------------------------------------
module tb_uart_transmitter;

    localparam int CPB = 16;
`ifdef UART_TRANSMITTER_PARITY_EN
    localparam int NB           = 11;
    localparam int FRAME_CYCLES = 176;
`else
    localparam int NB           = 10;
    localparam int FRAME_CYCLES = 160;
`endif

    typedef struct {
        logic [7:0] data;
        logic [7:0] order;  // data bits in line order, first sent at [7]
        logic       par;    // even parity of data
        string      name;
    } vec_t;

    logic clk;
    logic rst_n;
    logic serial;
    logic busy;

    int checks;
    int failures;

    uart_transmitter_if bus ();

    uart_transmitter #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .tx     (bus),
        .serial (serial),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Loopback receiver: finds the start edge, samples mid-bit.
    // ------------------------------------------------------------------
    logic [7:0] rx_bytes[$];

    initial begin : rx_model
        logic [7:0] b;
        b = '0;
        forever begin
            @(negedge serial);
            repeat (CPB / 2) @(posedge clk);
            if (serial == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(posedge clk);
                    b[i] = serial;
                end
`ifdef UART_TRANSMITTER_PARITY_EN
                repeat (CPB) @(posedge clk);
`endif
                repeat (CPB) @(posedge clk);
                if (serial == 1'b1) rx_bytes.push_back(b);
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [7:0] d, input logic [7:0] o,
                                input logic p, input string n);
        vec_t v;
        v.data  = d;
        v.order = o;
        v.par   = p;
        v.name  = n;
        return v;
    endfunction

    // Waits (bounded) for ready, offers a byte and steps over the accepting
    // edge. Returns at the sample point just after that edge.
    task automatic offer(input logic [7:0] d, input bit hold);
        int n;
        n = 0;
        while (bus.ready !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        if (bus.ready !== 1'b1) check("ready_timeout", bus.ready, 1);
        bus.data  = d;
        bus.valid = 1'b1;
        step();
        if (!hold) bus.valid = 1'b0;
    endtask

    // Called at the sample point right after the accepting edge. Checks
    // every cycle of every bit, busy duration and ready timing. poke_at>0
    // changes data and pulses valid at that frame cycle.
    task automatic check_frame(input vec_t v, input int poke_at);
        int   bad;
        int   busy_cnt;
        int   cyc;
        logic exp_bit;
        check({v.name, "_latency_serial_idle"}, serial, 1'b1);
        check({v.name, "_ready_low"}, bus.ready, 1'b0);
        busy_cnt = 0;
        cyc      = 0;
        for (int b = 0; b < NB; b++) begin
            if (b == 0)           exp_bit = 1'b0;
            else if (b <= 8)      exp_bit = v.order[8 - b];
            else if (b == NB - 1) exp_bit = 1'b1;
            else                  exp_bit = v.par;
            bad = 0;
            for (int c = 0; c < CPB; c++) begin
                step();
                cyc++;
                if (cyc == poke_at) begin
                    bus.data  = 8'h3C;
                    bus.valid = 1'b1;
                end else if (poke_at > 0 && cyc == poke_at + 1) begin
                    bus.valid = 1'b0;
                end
                if (serial !== exp_bit) bad++;
                if (busy === 1'b1) busy_cnt++;
                if (b == NB - 1 && c == CPB - 2)
                    check({v.name, "_ready_before_end"}, bus.ready, 1'b0);
            end
            check($sformatf("%s_bit%0d_bad_cycles", v.name, b), bad, 0);
        end
        check({v.name, "_ready_at_end"}, bus.ready, 1'b1);
        check({v.name, "_busy_cycles"}, busy_cnt, FRAME_CYCLES);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin : main
        vec_t       vecs[5];
        vec_t       v;
        logic [7:0] lb[3];
        int         bad;
        int         n;

        vecs[0] = mk(8'hA5, 8'b1010_0101, 1'b0, "tbl_A5");
        vecs[1] = mk(8'h07, 8'b1110_0000, 1'b1, "tbl_07");
        vecs[2] = mk(8'h03, 8'b1100_0000, 1'b0, "tbl_03");
        vecs[3] = mk(8'h80, 8'b0000_0001, 1'b1, "tbl_80");
        vecs[4] = mk(8'h3C, 8'b0011_1100, 1'b0, "tbl_3C");
        lb[0] = 8'h00;
        lb[1] = 8'hFF;
        lb[2] = 8'h81;

        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.valid = 1'b0;
        bus.data  = 8'h00;

        // Reset state
        repeat (3) step();
        check("reset_serial", serial, 1'b1);
        check("reset_ready", bus.ready, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst_n = 1'b1;
        step();
        check("ready_first_edge_after_release", bus.ready, 1'b1);

        // Table-driven single frames
        for (int i = 0; i < 5; i++) begin
            offer(vecs[i].data, 1'b0);
            check_frame(vecs[i], -1);
            step();
            check({vecs[i].name, "_busy_after"}, busy, 1'b0);
            check({vecs[i].name, "_serial_after"}, serial, 1'b1);
        end

        // Back-to-back: valid held, data changed to FF during the first
        // frame; first frame must still carry 00.
        offer(8'h00, 1'b1);
        bus.data = 8'hFF;
        check_frame(mk(8'h00, 8'b0000_0000, 1'b0, "b2b_00"), -1);
        step();  // second accept happens on this edge
        check("b2b_idle_gap_serial", serial, 1'b1);
        check("b2b_idle_gap_busy", busy, 1'b0);
        bus.valid = 1'b0;
        check_frame(mk(8'hFF, 8'b1111_1111, 1'b0, "b2b_FF"), -1);
        step();
        check("b2b_busy_after", busy, 1'b0);

        // Ignored input: data to 3C and valid pulse mid-frame
        offer(8'h12, 1'b0);
        check_frame(mk(8'h12, 8'b0100_1000, 1'b0, "ign_12"), 40);
        step();
        bad = 0;
        for (int c = 0; c < 3 * CPB; c++) begin
            step();
            if (serial !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("ign_no_second_frame", bad, 0);

        // Reset during bit 3 of 55
        offer(8'h55, 1'b0);
        repeat (68) step();
        check("rst_mid_pre_bit3", serial, 1'b0);
        rst_n = 1'b0;
        step();
        check("rst_mid_serial", serial, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_ready", bus.ready, 1'b0);
        rst_n = 1'b1;
        step();
        check("rst_mid_ready_after_release", bus.ready, 1'b1);
        bad = 0;
        for (int c = 0; c < 12 * CPB; c++) begin
            step();
            if (serial !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("rst_mid_no_resume", bad, 0);

        // Loopback through the receiver model
        rx_bytes.delete();
        for (int i = 0; i < 3; i++) begin
            offer(lb[i], 1'b0);
            n = 0;
            while (rx_bytes.size() == 0 && n < NB * CPB + 2 * CPB) begin
                step();
                n++;
            end
            if (rx_bytes.size() == 0) begin
                check($sformatf("loopback_%0d_timeout", i), rx_bytes.size(), 1);
            end else begin
                v.data = rx_bytes.pop_front();
                check($sformatf("loopback_%0h", lb[i]), v.data, lb[i]);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_transmitter

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit period; legal range is 2..65535.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port data, input, 8, the byte to send.
REQ-005 SHALL have port valid, input, 1; high means data is offered.
REQ-006 SHALL have port ready, output, 1; high means a byte can be accepted this cycle.
REQ-007 SHALL have port serial, output, 1, the line to the receiver; idle level is 1.
REQ-008 SHALL have port busy, output, 1; high while a frame is on the line.

Function
REQ-009 SHALL accept a byte on a rising edge where valid=1 and ready=1, and latch data into an internal shift register.
REQ-010 SHALL drive ready=1 only in IDLE; ready is registered.
REQ-011 SHALL ignore data and valid while ready=0; changes to data after acceptance SHALL NOT affect the frame.
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY (only when configured), and STOP.
REQ-013 SHALL make these transitions: IDLE->START on accept; START->DATA after one bit period; DATA->PARITY or STOP after bit 7; PARITY->STOP after one period; STOP->IDLE after one period.
REQ-014 SHALL drive serial=0 in START, serial=data bit in DATA sent LSB first, and serial=1 in STOP and IDLE.
REQ-015 SHALL hold each bit for exactly CLKS_PER_BIT cycles, timed by a baud counter that resets to 0 on each state entry.
REQ-016 SHALL make serial fall on the first edge after the accepting edge, a latency of 1 cycle.
REQ-017 SHALL make the frame length exactly 10*CLKS_PER_BIT cycles, or 11*CLKS_PER_BIT with parity.
REQ-018 SHALL drive ready=1 on the cycle after STOP completes, so back-to-back frames with valid held high are separated only by the full stop bit plus 1 IDLE cycle.
REQ-019 SHALL drive busy=1 from the first START cycle through the last STOP cycle, and 0 otherwise.
REQ-020 SHALL keep the bit index counter 3 bits wide, wrapping 7->0 only on the DATA exit.
REQ-021 SHALL register serial and leave no combinational path from any input to serial.

Reset
REQ-022 SHALL, when rst_n=0 at a clock edge, set state=IDLE, serial=1, ready=0, busy=0, and clear all counters.
REQ-023 SHALL drive ready=1 on the first edge with rst_n=1.
REQ-024 SHALL abandon a frame on reset mid-frame, with serial returning to 1 on that same edge; no partial-frame resume is permitted.

Configuration
REQ-025 SHALL support macro UART_TRANSMITTER_PARITY_EN.
REQ-026 SHALL, when the macro is defined, insert the PARITY state and send an even parity bit (XOR of the 8 data bits) between bit 7 and STOP.
REQ-027 SHALL, when the macro is undefined, omit the PARITY state and parity logic entirely, going DATA->STOP.

Structure
REQ-028 SHALL place the state enum typedef, FRAME_DATA_BITS=8, IDLE_LEVEL=1'b1, and the default CLKS_PER_BIT in shared package uart_pkg, which the receiver also uses.
REQ-029 SHALL place the baud counter in sub-module uart_baud_gen (inputs clk, rst_n, restart; output tick), parameterized by CLKS_PER_BIT.

Verification
REQ-030 SHALL check basic send: reset, then data=8'hA5, valid=1 for 1 cycle, CLKS_PER_BIT=16 -> serial reads 0,1,0,1,0,0,1,0,1,1, each held 16 cycles; ready returns 1 at cycle 161 after accept.
REQ-031 SHALL check back-to-back: valid held high with 8'h00 then 8'hFF -> two frames; the second start bit begins exactly 1 cycle after the first stop bit ends; no glitch on serial.
REQ-032 SHALL check ignored input: data changed to 8'h3C and valid pulsed mid-frame -> the in-flight frame is unchanged and no second frame is sent.
REQ-033 SHALL check reset mid-frame: rst_n=0 during bit 3 of 8'h55 -> serial=1, busy=0, ready=0 on that edge; ready=1 one edge after release.
REQ-034 SHALL check parity with UART_TRANSMITTER_PARITY_EN defined: 8'h07 -> parity bit 1; 8'h03 -> parity bit 0; frame is 176 cycles at CLKS_PER_BIT=16.
REQ-035 SHALL check loopback: serial wired to the receiver with the same CLKS_PER_BIT, sending 8'h00, 8'hFF, and 8'h81 -> the receiver output matches each byte.
